// File: rtl/alu_pkg.sv
// Shared ALU issue-stage package: widths, opcode encodings and
// the reserved-opcode helper used by the issue stage.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int OPW   = 4;

  localparam logic [OPW-1:0] OP_MOVE     = 4'd0;
  localparam logic [OPW-1:0] OP_NOT      = 4'd1;
  localparam logic [OPW-1:0] OP_ADD      = 4'd2;
  localparam logic [OPW-1:0] OP_SUB      = 4'd3;
  localparam logic [OPW-1:0] OP_OR       = 4'd4;
  localparam logic [OPW-1:0] OP_AND      = 4'd5;
  localparam logic [OPW-1:0] OP_XOR      = 4'd6;
  localparam logic [OPW-1:0] OP_SLT      = 4'd7;
  localparam logic [OPW-1:0] OP_SLTU     = 4'd8;
  localparam logic [OPW-1:0] OP_MERGE_LO = 4'd9;
  localparam logic [OPW-1:0] OP_MERGE_HI = 4'd10;

  // Opcodes 11-15 retire as NOPs: no write, no wb pulse.
  function automatic logic is_reserved(input logic [OPW-1:0] op);
    return op > OP_MERGE_HI;
  endfunction

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// 2-read/1-write register file with debug read port, r0 hard-zero.
// Ports: clk, rst_n, a/b/dbg read (addr->data), we/waddr/wdata write.
module reg_file_2r1w #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    a_addr,
  output logic [WIDTH-1:0] a_data,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign a_data   = (a_addr   == '0) ? '0 : mem[a_addr];
  assign b_data   = (b_addr   == '0) ? '0 : mem[b_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding a combinational ALU: operand read with one-level
// forwarding, EX register onto alu_*, writeback of alu_result to rd.
module alu_issue_stage #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int AW    = alu_pkg::AW,
  parameter int OPW   = alu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic             hold,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [WIDTH-1:0] wb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  import alu_pkg::*;

  logic             ex_valid;
  logic [AW-1:0]    ex_rd;
  logic             ex_writes;
  logic             accept;
  logic             retire;
  logic             fwd_ok;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  assign in_ready  = ~hold;
  assign accept    = in_valid & ~hold;
  assign retire    = ex_valid & ~hold;
  assign ex_writes = ~is_reserved(alu_opcode);
  assign fwd_ok    = retire & ex_writes;

  reg_file_2r1w #(
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_addr  (in_rs),
    .a_data  (rf_a),
    .b_addr  (in_rt),
    .b_data  (rf_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (fwd_ok),
    .waddr   (ex_rd),
    .wdata   (alu_result)
  );

  // The EX result lands in the regfile on the same edge the
  // dependent instruction is captured, so it must be bypassed.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
    if (in_rs == '0)
      op_a = '0;
    else if (fwd_ok && ex_rd == in_rs)
      op_a = alu_result;
    if (in_rt == '0)
      op_b = '0;
    else if (fwd_ok && ex_rd == in_rt)
      op_b = alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      alu_r2     <= '0;
      alu_r3     <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      ex_valid   <= 1'b1;
      ex_rd      <= in_rd;
      alu_r2     <= op_a;
      alu_r3     <= op_b;
      alu_opcode <= in_opcode;
    end else if (!hold) begin
      ex_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= retire & ex_writes;
      if (retire) begin
        wb_rd   <= ex_rd;
        wb_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU,
// a reference register model and a writeback scoreboard.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [4:0]  in_rd, in_rs, in_rt;
  logic        hold;
  logic [31:0] alu_r2, alu_r3;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rf [32];
  logic [36:0] sbq [$];
  logic [36:0] ent;
  logic [31:0] keep_r2, keep_r3;
  logic [3:0]  keep_op;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .hold      (hold),
    .alu_r2    (alu_r2),
    .alu_r3    (alu_r3),
    .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  function automatic logic [31:0] alu_f(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return ~a;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a | b;
      4'd5:    return a & b;
      4'd6:    return a ^ b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd9:    return {a[31:16], b[15:0]};
      4'd10:   return {b[31:16], a[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_opcode, alu_r2, alu_r3);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("wb_extra", {27'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        ent = sbq.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, ent[36:32]});
        chk("wb_data", wb_data, ent[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt);
    logic [31:0] a, b, r;
    a = exp_rf[rs];
    b = exp_rf[rt];
    r = alu_f(op, a, b);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs     = rs;
    in_rt     = rt;
    if (op <= 4'd10) begin
      sbq.push_back({rd, r});
      if (rd != 5'd0) exp_rf[rd] = r;
    end
    step();
    in_valid = 1'b0;
    chk("iss_r2", alu_r2, a);
    chk("iss_r3", alu_r3, b);
    chk("iss_op", {28'd0, alu_opcode}, {28'd0, op});
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] addr);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, exp_rf[addr]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0;
    in_rd = '0; in_rs = '0; in_rt = '0;
    hold = 1'b0; dbg_addr = '0;
    #23;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_r2", alu_r2, 32'd0);
    chk("rst_r3", alu_r3, 32'd0);
    chk("rst_op", {28'd0, alu_opcode}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
    chk("rst_wbrd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wbd", wb_data, 32'd0);
    for (int i = 0; i < 32; i++) dbg_chk("rst_dbg", 5'(i));
    step();

    // back-to-back dependent issue
    issue(4'd1, 5'd1, 5'd0, 5'd0);
    issue(4'd2, 5'd2, 5'd1, 5'd1);
    chk("fwd_r2", alu_r2, 32'hFFFF_FFFF);
    chk("fwd_r3", alu_r3, 32'hFFFF_FFFF);
    step(); step();
    dbg_chk("dbg_r2", 5'd2);
    chk("dbg_r2_val", dbg_data, 32'hFFFF_FFFE);

    // r0 protection
    issue(4'd1, 5'd0, 5'd0, 5'd0);
    issue(4'd0, 5'd3, 5'd0, 5'd0);
    chk("r0_move", alu_r2, 32'd0);

    // hold with SUB in EX
    issue(4'd3, 5'd4, 5'd1, 5'd2);
    hold = 1'b1;
    #1;
    keep_r2 = alu_r2; keep_r3 = alu_r3; keep_op = alu_opcode;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_wbv", {31'd0, wb_valid}, 32'd0);
      chk("hold_r2", alu_r2, keep_r2);
      chk("hold_r3", alu_r3, keep_r3);
      chk("hold_op", {28'd0, alu_opcode}, {28'd0, keep_op});
      dbg_addr = 5'd4;
      #1;
      chk("hold_r4", dbg_data, 32'd0);
    end
    hold = 1'b0;
    step();
    chk("rel_wbv", {31'd0, wb_valid}, 32'd1);
    chk("rel_wbrd", {27'd0, wb_rd}, 32'd4);
    step();
    dbg_chk("dbg_r4", 5'd4);
    dbg_chk("dbg_r0", 5'd0);

    // reserved opcode must not write or forward
    issue(4'd2, 5'd5, 5'd1, 5'd0);
    issue(4'd12, 5'd5, 5'd2, 5'd2);
    issue(4'd0, 5'd7, 5'd5, 5'd0);
    chk("rsv_nofwd", alu_r2, 32'hFFFF_FFFF);
    step(); step();
    dbg_chk("dbg_r5", 5'd5);
    dbg_chk("dbg_r7", 5'd7);
    step(); step();

    // async reset with an instruction in EX
    in_valid = 1'b1; in_opcode = 4'd2;
    in_rd = 5'd6; in_rs = 5'd1; in_rt = 5'd1;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_r2", alu_r2, 32'd0);
    chk("mid_r3", alu_r3, 32'd0);
    chk("mid_wbv", {31'd0, wb_valid}, 32'd0);
    chk("mid_wbd", wb_data, 32'd0);
    sbq.delete();
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("post_wbv", {31'd0, wb_valid}, 32'd0);
    dbg_chk("post_r6", 5'd6);
    dbg_chk("post_r1", 5'd1);

    // a post-reset sanity op
    issue(4'd6, 5'd8, 5'd0, 5'd0);
    step(); step();
    dbg_chk("post_r8", 5'd8);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
